// File: rtl/sp_ctrl_pkg.sv
// Shared widths and FSM states for the SP issue controller.
// Imported by the FIFO and the issue controller top.
package sp_ctrl_pkg;

    localparam int INSTR_W = 14;
    localparam int DATA_W  = 8;
    localparam int GAP_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT
    } sp_ctrl_state_t;

endpackage

// File: rtl/sp_sync_fifo.sv
// Single-clock FIFO with registered storage and occupancy count.
// clr empties the queue; a push while full lands only if a pop frees a slot.
module sp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sp_issue_ctrl.sv
// Buffers host instructions, issues them to SP under its busy handshake,
// and queues SP results for the host.
module sp_issue_ctrl
    import sp_ctrl_pkg::*;
#(
    parameter int IQ_DEPTH  = 4,
    parameter int RQ_DEPTH  = 4,
    parameter int ISSUE_GAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_valid,
    input  logic [INSTR_W-1:0] host_instr,
    output logic               host_ready,
    input  logic               flush,
    output logic               sp_in_valid,
    output logic [INSTR_W-1:0] sp_instruction,
    input  logic               sp_busy,
    input  logic               sp_out_valid,
    input  logic [DATA_W-1:0]  sp_out,
    output logic               res_valid,
    output logic [DATA_W-1:0]  res_data,
    input  logic               res_ready,
    output logic               idle,
    output logic               overflow,
    output logic [7:0]         issue_count
);

    sp_ctrl_state_t state;
    sp_ctrl_state_t state_nx;

    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_nx;
    logic               iq_pop;
    logic               iq_full;
    logic               iq_empty;
    logic [INSTR_W-1:0] iq_rdata;
    logic               rq_full;
    logic               rq_empty;
    logic               rq_drop;

    logic [$clog2(IQ_DEPTH):0] iq_level_unused;
    logic [$clog2(RQ_DEPTH):0] rq_level_unused;

    sp_sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (host_valid && host_ready),
        .pop   (iq_pop),
        .wdata (host_instr),
        .rdata (iq_rdata),
        .full  (iq_full),
        .empty (iq_empty),
        .count (iq_level_unused)
    );

    sp_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RQ_DEPTH)
    ) u_rq (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .push  (sp_out_valid),
        .pop   (res_ready),
        .wdata (sp_out),
        .rdata (res_data),
        .full  (rq_full),
        .empty (rq_empty),
        .count (rq_level_unused)
    );

    assign host_ready = !iq_full;
    assign res_valid  = !rq_empty;
    assign rq_drop    = sp_out_valid && rq_full && !res_ready;
    assign idle       = iq_empty && (state == S_IDLE) && !sp_busy;

    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        iq_pop   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!iq_empty && !sp_busy) begin
                    state_nx = S_ISSUE;
                    iq_pop   = 1'b1;
                end
            end
            S_ISSUE: begin
                state_nx = S_GAP;
                gap_nx   = '0;
            end
            // busy is not trusted until SP has had time to raise it
            S_GAP: begin
                if (gap_cnt == GAP_W'(ISSUE_GAP - 1)) begin
                    state_nx = S_WAIT;
                end else begin
                    gap_nx = gap_cnt + GAP_W'(1);
                end
            end
            S_WAIT: begin
                if (!sp_busy) begin
                    if (!iq_empty) begin
                        state_nx = S_ISSUE;
                        iq_pop   = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            gap_cnt        <= '0;
            sp_in_valid    <= 1'b0;
            sp_instruction <= '0;
            issue_count    <= '0;
            overflow       <= 1'b0;
        end else begin
            state       <= state_nx;
            gap_cnt     <= gap_nx;
            sp_in_valid <= iq_pop;
            overflow    <= overflow | rq_drop;
            if (iq_pop) begin
                sp_instruction <= iq_rdata;
                issue_count    <= issue_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sp_issue_ctrl.sv
// Self-checking bench for sp_issue_ctrl: directed scenarios plus
// randomized traffic against queue-based reference models.
module tb_sp_issue_ctrl;

    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_valid;
    logic [13:0] host_instr;
    logic        host_ready;
    logic        flush;
    logic        sp_in_valid;
    logic [13:0] sp_instruction;
    logic        sp_busy;
    logic        sp_out_valid;
    logic [7:0]  sp_out;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready;
    logic        idle;
    logic        overflow;
    logic [7:0]  issue_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sp_issue_ctrl #(
        .IQ_DEPTH  (4),
        .RQ_DEPTH  (4),
        .ISSUE_GAP (GAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_valid     (host_valid),
        .host_instr     (host_instr),
        .host_ready     (host_ready),
        .flush          (flush),
        .sp_in_valid    (sp_in_valid),
        .sp_instruction (sp_instruction),
        .sp_busy        (sp_busy),
        .sp_out_valid   (sp_out_valid),
        .sp_out         (sp_out),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_ready      (res_ready),
        .idle           (idle),
        .overflow       (overflow),
        .issue_count    (issue_count)
    );

    task automatic apply_reset;
        rst          = 1'b0;
        host_valid   = 1'b0;
        host_instr   = '0;
        flush        = 1'b0;
        sp_busy      = 1'b0;
        sp_out_valid = 1'b0;
        sp_out       = '0;
        res_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        host_valid   = 1'b0;
        host_instr   = '0;
        flush        = 1'b0;
        sp_busy      = 1'b0;
        sp_out_valid = 1'b0;
        sp_out       = '0;
        res_ready    = 1'b0;
        #1 rst = 1'b0;
        #2;
        n_checks++;
        if ({sp_in_valid, res_valid, overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000",
                     {sp_in_valid, res_valid, overflow});
        end
        n_checks++;
        if (sp_instruction !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_instr: got %h expected 0", sp_instruction);
        end
        n_checks++;
        if (res_data !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_res_data: got %h expected 0", res_data);
        end
        n_checks++;
        if (issue_count !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", issue_count);
        end
        n_checks++;
        if ({host_ready, idle} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready_idle: got %b expected 11",
                     {host_ready, idle});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_latency;
        int pc[$];
        logic [13:0] pw[$];
        int acc[$];
        int e;
        int prev_e;
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (sp_in_valid) begin
                pc.push_back(c);
                pw.push_back(sp_instruction);
            end
            host_valid = (c < 3);
            host_instr = 14'(c + 1);
            if (host_valid && host_ready) acc.push_back(c);
        end
        host_valid = 1'b0;
        n_checks++;
        if (pc.size() != 3) begin
            n_fail++;
            $display("FAIL latency_pulses: got %0d expected 3", pc.size());
        end
        prev_e = -100;
        for (int i = 0; i < pc.size() && i < acc.size(); i++) begin
            e = acc[i] + 2;
            if (prev_e + 2 + GAP > e) e = prev_e + 2 + GAP;
            n_checks++;
            if (pc[i] != e) begin
                n_fail++;
                $display("FAIL latency_cycle%0d: got %0d expected %0d",
                         i, pc[i], e);
            end
            n_checks++;
            if (pw[i] !== 14'(i + 1)) begin
                n_fail++;
                $display("FAIL latency_word%0d: got %h expected %h",
                         i, pw[i], 14'(i + 1));
            end
            prev_e = e;
        end
        n_checks++;
        if (issue_count !== 8'd3) begin
            n_fail++;
            $display("FAIL latency_count: got %0d expected 3", issue_count);
        end
    endtask

    task automatic test_backpressure;
        int acc;
        int pulse_c;
        int acc_c;
        bit got5;
        logic [13:0] first_w;
        apply_reset();
        sp_busy = 1'b1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            host_valid = 1'b1;
            host_instr = 14'(14'h100 + acc);
            if (host_ready) acc++;
        end
        @(negedge clk);
        n_checks++;
        if (acc != 4) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d expected 4", acc);
        end
        n_checks++;
        if (host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_full: got %b expected 0", host_ready);
        end
        sp_busy = 1'b0;
        got5 = 1'b0;
        pulse_c = -1;
        acc_c = -1;
        first_w = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sp_in_valid && pulse_c < 0) begin
                pulse_c = c;
                first_w = sp_instruction;
            end
            if (!got5) begin
                host_valid = 1'b1;
                if (host_ready) begin
                    got5 = 1'b1;
                    acc_c = c;
                end
            end else begin
                host_valid = 1'b0;
            end
        end
        host_valid = 1'b0;
        n_checks++;
        if (pulse_c < 0 || acc_c != pulse_c) begin
            n_fail++;
            $display("FAIL bp_fifth_accept: got cycle %0d expected %0d",
                     acc_c, pulse_c);
        end
        n_checks++;
        if (first_w !== 14'h100) begin
            n_fail++;
            $display("FAIL bp_first_word: got %h expected 100", first_w);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (idle) break;
        end
        n_checks++;
        if (idle !== 1'b1 || issue_count !== 8'd5) begin
            n_fail++;
            $display("FAIL bp_drain: got idle=%b count=%0d expected 1/5",
                     idle, issue_count);
        end
    endtask

    task automatic test_busy_hold;
        int np;
        apply_reset();
        @(negedge clk);
        host_valid = 1'b1;
        host_instr = 14'h0AA;
        @(negedge clk);
        host_instr = 14'h0BB;
        @(negedge clk);
        host_valid = 1'b0;
        n_checks++;
        if (sp_in_valid !== 1'b1 || sp_instruction !== 14'h0AA) begin
            n_fail++;
            $display("FAIL busy_first: got %b/%h expected 1/0aa",
                     sp_in_valid, sp_instruction);
        end
        sp_busy = 1'b1;
        np = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sp_in_valid) np++;
        end
        n_checks++;
        if (np != 0) begin
            n_fail++;
            $display("FAIL busy_hold: got %0d pulses expected 0", np);
        end
        sp_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sp_in_valid !== 1'b1 || sp_instruction !== 14'h0BB) begin
            n_fail++;
            $display("FAIL busy_release: got %b/%h expected 1/0bb",
                     sp_in_valid, sp_instruction);
        end
    endtask

    task automatic test_result_random;
        logic [7:0] mq[$];
        logic mov;
        logic v;
        logic r;
        logic [7:0] d;
        bit pop;
        bit push_ok;
        apply_reset();
        mov = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL rq_valid c%0d: got %b expected %b",
                         c, res_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                n_checks++;
                if (res_data !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rq_data c%0d: got %h expected %h",
                             c, res_data, mq[0]);
                end
            end
            n_checks++;
            if (overflow !== mov) begin
                n_fail++;
                $display("FAIL rq_overflow c%0d: got %b expected %b",
                         c, overflow, mov);
            end
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            r = ($urandom_range(0, 9) < 4);
            sp_out_valid = v;
            sp_out = d;
            res_ready = r;
            pop = r && (mq.size() > 0);
            push_ok = v && (mq.size() < 4 || pop);
            if (v && !push_ok) mov = 1'b1;
            if (pop) void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
        end
        sp_out_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic test_overflow;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sp_out_valid = 1'b1;
            sp_out = 8'(8'h11 + i);
        end
        @(negedge clk);
        sp_out_valid = 1'b0;
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b expected 1", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 8'(8'h11 + i)) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: got %b/%h expected 1/%h",
                         i, res_valid, res_data, 8'(8'h11 + i));
            end
            res_ready = 1'b1;
            @(negedge clk);
        end
        res_ready = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_empty: got %b expected 0", res_valid);
        end
        for (int i = 0; i < 5; i++) begin
            sp_out_valid = 1'b1;
            sp_out = 8'(8'hA0 + i);
            res_ready = (i == 4);
            @(negedge clk);
        end
        sp_out_valid = 1'b0;
        res_ready = 1'b0;
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 8'(8'hA0 + i)) begin
                n_fail++;
                $display("FAIL full_pushpop%0d: got %b/%h expected 1/%h",
                         i, res_valid, res_data, 8'(8'hA0 + i));
            end
            res_ready = 1'b1;
            @(negedge clk);
        end
        res_ready = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pushpop_empty: got %b expected 0", res_valid);
        end
    endtask

    task automatic test_flush;
        int got;
        int np;
        apply_reset();
        sp_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            host_valid = 1'b1;
            host_instr = 14'(14'h300 + i);
        end
        @(negedge clk);
        host_valid = 1'b0;
        sp_busy = 1'b0;
        got = -1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (sp_in_valid) begin
                got = c;
                break;
            end
        end
        n_checks++;
        if (got != 0 || sp_instruction !== 14'h300) begin
            n_fail++;
            $display("FAIL flush_issue: got c%0d/%h expected c0/300",
                     got, sp_instruction);
        end
        @(negedge clk);
        flush = 1'b1;
        sp_busy = 1'b1;
        host_valid = 1'b1;
        host_instr = 14'h3FF;
        @(negedge clk);
        flush = 1'b0;
        host_valid = 1'b0;
        n_checks++;
        if (host_ready !== 1'b1 || idle !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: got ready=%b idle=%b expected 1/0",
                     host_ready, idle);
        end
        repeat (3) @(negedge clk);
        sp_busy = 1'b0;
        np = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (sp_in_valid) np++;
        end
        n_checks++;
        if (np != 0) begin
            n_fail++;
            $display("FAIL flush_pulses: got %0d expected 0", np);
        end
        n_checks++;
        if (idle !== 1'b1 || issue_count !== 8'd1) begin
            n_fail++;
            $display("FAIL flush_idle: got idle=%b count=%0d expected 1/1",
                     idle, issue_count);
        end
    endtask

    task automatic test_random_issue;
        logic [13:0] exp_q[$];
        logic [13:0] w;
        int np;
        logic prev;
        apply_reset();
        np = 0;
        prev = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (sp_in_valid) begin
                np++;
                n_checks++;
                if (prev) begin
                    n_fail++;
                    $display("FAIL rnd_back_to_back c%0d: got 11 expected 01",
                             c);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_spurious c%0d: got %h expected none",
                             c, sp_instruction);
                end else begin
                    w = exp_q.pop_front();
                    if (sp_instruction !== w) begin
                        n_fail++;
                        $display("FAIL rnd_order c%0d: got %h expected %h",
                                 c, sp_instruction, w);
                    end
                end
            end
            prev = sp_in_valid;
            if (c < 300) begin
                host_valid = 1'($urandom_range(0, 1));
                host_instr = 14'($urandom);
                sp_busy = ($urandom_range(0, 9) < 3);
            end else begin
                host_valid = 1'b0;
                sp_busy = 1'b0;
            end
            if (host_valid && host_ready) exp_q.push_back(host_instr);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_leftover: got %0d expected 0", exp_q.size());
        end
        n_checks++;
        if (issue_count !== 8'(np)) begin
            n_fail++;
            $display("FAIL rnd_count: got %0d expected %0d",
                     issue_count, 8'(np));
        end
    endtask

    task automatic test_wrap;
        int acc;
        int np;
        apply_reset();
        acc = 0;
        np = 0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (sp_in_valid) np++;
            if (acc == 257 && idle) break;
            host_valid = (acc < 257);
            host_instr = 14'(acc);
            if (host_valid && host_ready) acc++;
        end
        host_valid = 1'b0;
        n_checks++;
        if (acc != 257 || idle !== 1'b1 || np != 257) begin
            n_fail++;
            $display("FAIL wrap_run: got acc=%0d pulses=%0d expected 257",
                     acc, np);
        end
        n_checks++;
        if (issue_count !== 8'd1) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d expected 1", issue_count);
        end
    endtask

    task automatic test_reset_mid_wait;
        int np;
        apply_reset();
        sp_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            host_valid = (i < 4);
            host_instr = 14'(14'h200 + i);
            sp_out_valid = 1'b1;
            sp_out = 8'(8'h40 + i);
        end
        @(negedge clk);
        host_valid = 1'b0;
        sp_out_valid = 1'b0;
        sp_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sp_in_valid !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_setup: got pulse=%b ovf=%b expected 1/1",
                     sp_in_valid, overflow);
        end
        sp_busy = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({sp_in_valid, res_valid, overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL rw_flags: got %b expected 000",
                     {sp_in_valid, res_valid, overflow});
        end
        n_checks++;
        if (sp_instruction !== 14'h0 || res_data !== 8'h0) begin
            n_fail++;
            $display("FAIL rw_data: got %h/%h expected 0/0",
                     sp_instruction, res_data);
        end
        n_checks++;
        if (issue_count !== 8'd0 || host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_count: got %0d/%b expected 0/1",
                     issue_count, host_ready);
        end
        sp_busy = 1'b0;
        #1;
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_idle: got %b expected 1", idle);
        end
        @(negedge clk);
        rst = 1'b1;
        np = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (sp_in_valid) np++;
        end
        n_checks++;
        if (np != 0) begin
            n_fail++;
            $display("FAIL rw_queue_cleared: got %0d pulses expected 0", np);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_busy_hold();
        test_result_random();
        test_overflow();
        test_flush();
        test_random_issue();
        test_wrap();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
